// File: rtl/logic_unit_pkg.sv
// logic_unit_pkg: shared opcodes, FSM states and default width for the logic unit arbiter
package logic_unit_pkg;
    localparam int WIDTH_DEF = 32;
    localparam logic [2:0] OP_AND    = 3'b000;
    localparam logic [2:0] OP_OR     = 3'b001;
    localparam logic [2:0] OP_XOR    = 3'b010;
    localparam logic [2:0] OP_NOR    = 3'b011;
    localparam logic [2:0] OP_NAND   = 3'b100;
    localparam logic [2:0] OP_XNOR   = 3'b101;
    localparam logic [2:0] OP_PASS_A = 3'b110;
    localparam logic [2:0] OP_NOT_A  = 3'b111;
    typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_t;
endpackage

// File: rtl/logic_unit_32.sv
// logic_unit_32: combinational bitwise logic unit, shared gate planes plus an 8:1 select
module logic_unit_32 import logic_unit_pkg::*; #(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result
);
    logic [WIDTH-1:0] and_w, or_w, xor_w;
    assign and_w = a & b;
    assign or_w  = a | b;
    assign xor_w = a ^ b;
    always_comb begin
        result = a;
        case (op)
            OP_AND:    result = and_w;
            OP_OR:     result = or_w;
            OP_XOR:    result = xor_w;
            OP_NOR:    result = ~or_w;
            OP_NAND:   result = ~and_w;
            OP_XNOR:   result = ~xor_w;
            OP_PASS_A: result = a;
            OP_NOT_A:  result = ~a;
            default:   result = a;
        endcase
    end
endmodule

// File: rtl/logic_unit_arbiter.sv
// logic_unit_arbiter: round-robin sharing of one logic unit between two requesters
// with a single registered result slot and valid/ready handshakes.
module logic_unit_arbiter import logic_unit_pkg::*; #(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [2:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [2:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero
);
    state_t           state;
    logic             last_grant;
    logic             slot_free, gnt_any, gnt_id;
    logic [2:0]       sel_op;
    logic [WIDTH-1:0] sel_a, sel_b, lu_result;
    // On contention the requester that did not win last time goes next.
    assign slot_free  = (state == ST_EMPTY) || rsp_ready;
    assign gnt_any    = slot_free && (req0_valid || req1_valid);
    assign gnt_id     = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
    assign req0_ready = gnt_any && !gnt_id;
    assign req1_ready = gnt_any && gnt_id;
    assign sel_op     = gnt_id ? req1_op : req0_op;
    assign sel_a      = gnt_id ? req1_a : req0_a;
    assign sel_b      = gnt_id ? req1_b : req0_b;
    assign rsp_valid  = (state == ST_FULL);
    logic_unit_32 #(.WIDTH(WIDTH)) u_lu (
        .op     (sel_op),
        .a      (sel_a),
        .b      (sel_b),
        .result (lu_result)
    );
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_EMPTY;
            last_grant <= 1'b1;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
        end else if (gnt_any) begin
            state      <= ST_FULL;
            last_grant <= gnt_id;
            rsp_id     <= gnt_id;
            rsp_result <= lu_result;
            rsp_zero   <= ~|lu_result;
        end else if (rsp_ready) begin
            state      <= ST_EMPTY;
        end
    end
endmodule

// File: tb/tb_logic_unit_arbiter.sv
// tb_logic_unit_arbiter: directed stimulus checked against a truth-table/slot model every cycle
module tb_logic_unit_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0, rsp_ready = 1'b0;
    logic [2:0]  req0_op = '0, req1_op = '0;
    logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic        req0_ready, req1_ready, rsp_valid, rsp_id, rsp_zero;
    logic [31:0] rsp_result;
    int total = 0;
    int bad = 0;

    logic_unit_arbiter dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_zero(rsp_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Each opcode as a truth table indexed by {a_bit, b_bit}.
    function automatic logic [31:0] model_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [3:0]  tt;
        logic [31:0] r;
        tt = op == 3'd0 ? 4'b1000 : op == 3'd1 ? 4'b1110 : op == 3'd2 ? 4'b0110 : op == 3'd3 ? 4'b0001 :
             op == 3'd4 ? 4'b0111 : op == 3'd5 ? 4'b1001 : op == 3'd6 ? 4'b1100 : 4'b0011;
        for (int i = 0; i < 32; i++) r[i] = tt[{a[i], b[i]}];
        return r;
    endfunction

    function automatic int pick(input logic v0, input logic v1, input logic last);
        if (!v0 && !v1) return -1;
        if (v0 && v1) return last ? 0 : 1;
        return v1 ? 1 : 0;
    endfunction

    logic        m_valid = 1'b0, m_id = 1'b0, m_zero = 1'b0, m_last = 1'b1;
    logic [31:0] m_result = '0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_valid <= 1'b0; m_id <= 1'b0; m_zero <= 1'b0; m_last <= 1'b1; m_result <= '0;
        end else if ((!m_valid || rsp_ready) && pick(req0_valid, req1_valid, m_last) >= 0) begin
            m_valid  <= 1'b1;
            m_id     <= pick(req0_valid, req1_valid, m_last) == 1;
            m_last   <= pick(req0_valid, req1_valid, m_last) == 1;
            m_result <= pick(req0_valid, req1_valid, m_last) == 1 ? model_op(req1_op, req1_a, req1_b)
                                                                  : model_op(req0_op, req0_a, req0_b);
            m_zero   <= (pick(req0_valid, req1_valid, m_last) == 1 ? model_op(req1_op, req1_a, req1_b)
                                                                   : model_op(req0_op, req0_a, req0_b)) == 0;
        end else if (rsp_ready) begin
            m_valid <= 1'b0;
        end
    end

    always @(negedge clk) begin
        int g;
        g = (!m_valid || rsp_ready) ? pick(req0_valid, req1_valid, m_last) : -1;
        chk("model req0_ready", req0_ready, g == 0);
        chk("model req1_ready", req1_ready, g == 1);
        chk("model rsp_valid", rsp_valid, m_valid);
        chk("model rsp_id", rsp_id, m_id);
        chk("model rsp_result", rsp_result, m_result);
        chk("model rsp_zero", rsp_zero, m_zero);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] op_exp [8] = '{32'hF000_F000, 32'hFFF0_FFF0, 32'h0FF0_0FF0, 32'h000F_000F,
                                32'h0FFF_0FFF, 32'hF00F_F00F, 32'hF0F0_F0F0, 32'h0F0F_0F0F};
    logic [1:0]  cont_exp = 2'b01;
    logic [31:0] held;

    initial begin
        reset = 1'b1;
        @(negedge clk);
        chk("reset rsp_valid", rsp_valid, 0);
        chk("reset rsp_id", rsp_id, 0);
        chk("reset rsp_result", rsp_result, 0);
        chk("reset rsp_zero", rsp_zero, 0);
        cyc();
        reset = 1'b0;
        // Single requester, NOR
        req0_valid = 1; req0_op = 3'b011; req0_a = 32'h0000_FFFF; req0_b = 32'h00FF_00FF; rsp_ready = 1;
        @(negedge clk);
        chk("single req0_ready", req0_ready, 1);
        chk("single req1_ready", req1_ready, 0);
        cyc();
        req0_valid = 0;
        @(negedge clk);
        chk("single rsp_valid", rsp_valid, 1);
        chk("single rsp_id", rsp_id, 0);
        chk("single rsp_result", rsp_result, 32'hFF00_0000);
        chk("single rsp_zero", rsp_zero, 0);
        // Continuous contention: last winner was 0, so 1,0,1,0
        cyc();
        req0_valid = 1; req0_op = 3'b000; req0_a = 32'h1234_5678; req0_b = 32'h0F0F_0F0F;
        req1_valid = 1; req1_op = 3'b001; req1_a = 32'hA0A0_A0A0; req1_b = 32'h0505_0505;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("contend req1_ready", req1_ready, cont_exp[i % 2]);
            chk("contend req0_ready", req0_ready, !cont_exp[i % 2]);
            if (i > 0) begin
                chk("contend no bubble", rsp_valid, 1);
                chk("contend rsp_id", rsp_id, cont_exp[(i - 1) % 2]);
            end
            cyc();
        end
        // Backpressure with both requesters waiting
        rsp_ready = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 0) held = rsp_result;
            chk("bp held result", rsp_result, 32'h0204_0608);
            chk("bp stable", rsp_result, held);
            chk("bp rsp_id", rsp_id, 0);
            chk("bp req0_ready", req0_ready, 0);
            chk("bp req1_ready", req1_ready, 0);
            cyc();
        end
        rsp_ready = 1;
        @(negedge clk);
        chk("bp release req1_ready", req1_ready, 1);
        cyc();
        @(negedge clk);
        chk("bp new rsp_id", rsp_id, 1);
        chk("bp new result", rsp_result, 32'hA5A5_A5A5);
        // Zero flag
        cyc();
        req1_valid = 0; req0_op = 3'b010; req0_a = 32'hDEAD_BEEF; req0_b = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("zero req0_ready", req0_ready, 1);
        cyc();
        req0_valid = 0;
        @(negedge clk);
        chk("zero rsp_result", rsp_result, 0);
        chk("zero rsp_zero", rsp_zero, 1);
        // Every opcode through requester 1
        req1_a = 32'hF0F0_F0F0; req1_b = 32'hFF00_FF00;
        for (int i = 0; i <= 8; i++) begin
            cyc();
            if (i < 8) begin
                req1_valid = 1; req1_op = 3'(i);
            end else begin
                req1_valid = 0;
            end
            if (i > 0) begin
                @(negedge clk);
                chk($sformatf("opcode %0d result", i - 1), rsp_result, op_exp[i - 1]);
                chk($sformatf("opcode %0d rsp_id", i - 1), rsp_id, 1);
            end
        end
        // Asynchronous reset while a result is held
        cyc();
        req0_valid = 1; req0_op = 3'b000; req0_a = 32'hFFFF_FFFF; req0_b = 32'h1; rsp_ready = 0;
        cyc();
        req1_valid = 1;
        @(negedge clk);
        chk("pre-reset rsp_valid", rsp_valid, 1);
        #1 reset = 1;
        #1;
        chk("async reset rsp_valid", rsp_valid, 0);
        chk("async reset rsp_result", rsp_result, 0);
        cyc();
        reset = 0;
        @(negedge clk);
        chk("post-reset req0_ready", req0_ready, 1);
        chk("post-reset req1_ready", req1_ready, 0);
        cyc();
        req0_valid = 0; req1_valid = 0; rsp_ready = 1;
        @(negedge clk);
        chk("post-reset rsp_result", rsp_result, 32'h1);
        cyc();
        cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/logic_unit_arbiter.md
# logic_unit_arbiter

- Shares one 32-bit bitwise logic unit (AND/OR/XOR/NOR family) between two requesters.
- Each requester presents an opcode and two operands over a valid/ready handshake.
- The arbiter grants one request per cycle in round-robin order, computes the result and holds it in a single output register until the consumer accepts it.
- It sits between the ALU operand-fetch stage and the result writeback path.

## Interface
Parameters:
- WIDTH, 32, operand/result width.

Ports (clock and reset are fixed: one clock; reset is asynchronous and active-high):
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- req0_valid  input  1  requester 0 has a request.
- req0_ready  output  1  requester 0 request accepted this cycle.
- req0_op  input  3  requester 0 opcode.
- req0_a, req0_b  input  WIDTH  requester 0 operands.
- req1_valid, req1_ready, req1_op, req1_a, req1_b  same as requester 0, for requester 1.
- rsp_valid  output  1  result register holds an unconsumed result.
- rsp_ready  input  1  consumer accepts the result.
- rsp_id  output  1  requester that produced the result.
- rsp_result  output  WIDTH  computed result.
- rsp_zero  output  1  rsp_result == 0.

## Operation
- Opcodes:
  - 000 AND, 001 OR, 010 XOR, 011 NOR.
  - 100 NAND, 101 XNOR, 110 PASS_A, 111 NOT_A.
  - All ops are bitwise with no carry. Result is exactly WIDTH bits.
- Two-state FSM:
  - EMPTY: output register free.
  - FULL: rsp_valid=1.
- Slot free this cycle: state==EMPTY, or (FULL and rsp_ready).
- Grant:
  - Only when the slot is free and at least one reqN_valid is set.
  - If exactly one requester is valid, it wins.
  - If both are valid, the requester not granted last wins.
  - last_grant updates only on an actual grant.
- reqN_ready is combinational: 1 only for the granted requester in the cycle of grant. Never both. Never asserted when the slot is not free.
- On grant, the next edge loads rsp_result, rsp_zero and rsp_id, and the FSM goes to (or stays in) FULL.
- FULL with rsp_ready and no grant: goes to EMPTY.
- Drain and new grant in the same cycle: stays FULL with the new data (back-to-back, no bubble).
- FULL without rsp_ready: output registers hold stable; no grants.
- Requester side: once reqN_valid is asserted, the requester holds valid/op/a/b until reqN_ready. The arbiter does not check this.

## Timing
- Reset values:
  - FSM EMPTY; rsp_valid=0, rsp_id=0, rsp_result=0, rsp_zero=0.
  - last_grant=1, so requester 0 wins the first contention.
- Latency: grant in cycle N, rsp_valid=1 with the result from edge N+1.
- Throughput: one result per cycle while rsp_ready is held high.
- Under continuous contention, grants alternate 0,1,0,1…
- A single always-valid requester gets every cycle when the other is idle.
- rsp_* are driven only from registers. reqN_ready depends combinationally on reqN_valid, rsp_ready and state.
- Reset asserted mid-operation:
  - Immediately clears rsp_valid and discards the pending result.
  - An in-flight grant in the reset cycle is lost; the requester must still hold valid and is re-granted after reset.

## Structure
- Shared package logic_unit_pkg:
  - opcode localparams: OP_AND … OP_NOT_A, 3 bits.
  - FSM state encoding: ST_EMPTY, ST_FULL.
  - WIDTH default.
- One combinational sub-module, logic_unit_32 (op, a, b -> result), built from the existing per-bit 32-bit gate blocks plus an 8:1 select.
- The arbiter instantiates one logic_unit_32 fed by a 2:1 operand/op mux on the grant.

## Test plan
- Reset, then req0 only:
  - Stimulus: op=011, a=0x0000_FFFF, b=0x00FF_00FF.
  - Required: req0_ready in cycle 0; next cycle rsp_valid=1, rsp_id=0, rsp_result=0xFF00_0000, rsp_zero=0.
- Both requesters valid continuously, rsp_ready=1:
  - Stimulus: req0 op=000, req1 op=001.
  - Required: grants 0,1,0,1 on consecutive cycles; rsp_id alternates; no bubble cycles.
- Backpressure:
  - Stimulus: rsp_ready=0 for 5 cycles with both requesters valid.
  - Required: one result held stable; reqN_ready=0 throughout. On rsp_ready=1, a new result appears the next cycle from the other requester.
- Zero flag:
  - Stimulus: op=010, a=b=0xDEAD_BEEF.
  - Required: rsp_result=0, rsp_zero=1.
- All 8 opcodes:
  - Stimulus: a=0xF0F0_F0F0, b=0xFF00_FF00.
  - Required results in opcode order: 0xF000_F000, 0xFFF0_FFF0, 0x0FF0_0FF0, 0x000F_000F, 0x0FFF_0FFF, 0xF00F_F00F, 0xF0F0_F0F0, 0x0F0F_0F0F.
- Reset mid-FULL:
  - Stimulus: assert reset while rsp_valid=1 and rsp_ready=0.
  - Required: rsp_valid drops asynchronously. After release, contention grants req0 first.
